pipe_fetch_stage: RTL and testbench

- Instruction-fetch (IF) stage of the 5-stage pipelined MIPS CPU. It sits directly upstream of the register file and decode stage.
- Owns the PC and drives the Avalon-style instruction read port.
- Registers fetched words into IF_ID_Instruction / IF_ID_PC, which feed register read and decode.
- Implements branch-delay-slot redirect, stall hold, and halt on fetch from address 0.

---
 rtl/pipe_fetch_stage_if.sv | 28 ++
 rtl/pipe_fetch_stage.sv | 112 +++++++++++
 tb/tb_pipe_fetch_stage.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_fetch_stage_if.sv
// ============================================================================
// pipe_fetch_stage_if : Avalon-style instruction read port of the fetch stage.
// Revision 1.0
// ============================================================================
`default_nettype none

interface pipe_fetch_stage_if;
    logic [31:0] instr_address;
    logic        instr_read;
    logic [31:0] instr_readdata;
    logic        waitrequest;

    modport master (
        output instr_address,
        output instr_read,
        input  instr_readdata,
        input  waitrequest
    );

    modport slave (
        input  instr_address,
        input  instr_read,
        output instr_readdata,
        output waitrequest
    );
endinterface

`default_nettype wire

// File: rtl/pipe_fetch_stage.sv
// ============================================================================
// pipe_fetch_stage : MIPS IF stage - PC, delay-slot redirect, stall hold, halt.
// Optional macro FETCH_PERF_CNT_EN adds fetch_count / stall_cycles outputs.
// Revision 1.0
// ============================================================================
`default_nettype none

module pipe_fetch_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] NOP_WORD     = 32'h00000000
) (
    input  wire logic             clk,
    input  wire logic             reset,
    pipe_fetch_stage_if.master    bus,
    input  wire logic             stall,
    input  wire logic             branch_taken,
    input  wire logic [31:0]      branch_target,
    output logic      [31:0]      IF_ID_Instruction,
    output logic      [31:0]      IF_ID_PC,
    output logic                  active
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic      [31:0]      fetch_count,
    output logic      [31:0]      stall_cycles
`endif
);

    typedef enum logic [1:0] {
        START  = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [31:0] target_aligned;
    logic [31:0] redirect_target;
    logic        redirect_pending;
    logic        accept;

    always_comb begin
        target_aligned = branch_target & ~32'd3;
        accept         = (state == FETCH) && !bus.waitrequest && !stall;
        // A fresh branch beats an older pending redirect; otherwise fall through.
        if (branch_taken)
            next_pc = target_aligned;
        else if (redirect_pending)
            next_pc = redirect_target;
        else
            next_pc = pc + 32'd4;
    end

    always_comb begin
        state_next = state;
        case (state)
            START:   if (!bus.waitrequest) state_next = FETCH;
            FETCH:   if (accept && (next_pc == 32'd0)) state_next = HALTED;
            HALTED:  state_next = HALTED;
            default: state_next = START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= START;
            pc                <= RESET_VECTOR;
            IF_ID_Instruction <= NOP_WORD;
            IF_ID_PC          <= 32'd0;
            redirect_pending  <= 1'b0;
            redirect_target   <= 32'd0;
        end else begin
            state <= state_next;
            if (accept) begin
                IF_ID_Instruction <= bus.instr_readdata;
                IF_ID_PC          <= pc;
                pc                <= next_pc;
                redirect_pending  <= 1'b0;
            end else if ((state == FETCH) && branch_taken) begin
                // Branch resolved while the delay slot is blocked: remember it.
                redirect_pending <= 1'b1;
                redirect_target  <= target_aligned;
            end
            if ((state == HALTED) && !bus.waitrequest)
                IF_ID_Instruction <= NOP_WORD;
        end
    end

    assign bus.instr_read    = (state == FETCH);
    assign bus.instr_address = pc;
    assign active            = (state != HALTED);

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count  <= 32'd0;
            stall_cycles <= 32'd0;
        end else if (state == FETCH) begin
            if (accept) begin
                if (fetch_count != 32'hFFFFFFFF)
                    fetch_count <= fetch_count + 32'd1;
            end else if (stall_cycles != 32'hFFFFFFFF) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_fetch_stage.sv
// ============================================================================
// tb_pipe_fetch_stage : directed plan plus random stimulus vs. reference model.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_pipe_fetch_stage;
    localparam logic [31:0] RV = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] IF_ID_Instruction;
    logic [31:0] IF_ID_PC;
    logic        active;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_cycles;
`endif

    pipe_fetch_stage_if bus ();

    pipe_fetch_stage dut (
        .clk               (clk),
        .reset             (reset),
        .bus               (bus.master),
        .stall             (stall),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .IF_ID_Instruction (IF_ID_Instruction),
        .IF_ID_PC          (IF_ID_PC),
        .active            (active)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count       (fetch_count),
        .stall_cycles      (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == RV) return 32'h24020005;
        return {addr[15:0], addr[31:16]} ^ 32'h13579BDF;
    endfunction

    always_comb bus.instr_readdata = mem_word(bus.instr_address);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: 0 = start cycle, 1 = fetching, 2 = halted
    int          m_phase;
    logic [31:0] m_pc, m_ifid_i, m_ifid_pc, m_ptgt;
    bit          m_pend;
    longint      m_fc, m_sc;

    function automatic void model_reset();
        m_phase = 0; m_pc = RV; m_ifid_i = 32'h0; m_ifid_pc = 32'h0;
        m_pend = 0; m_ptgt = 32'h0; m_fc = 0; m_sc = 0;
    endfunction

    task automatic cycle(input bit wr, input bit st, input bit bt,
                         input logic [31:0] tg, input bit rs);
        logic [31:0] np;
        logic [31:0] tga;
        bit acc;
        @(negedge clk);
        bus.waitrequest = wr; stall = st; branch_taken = bt;
        branch_target = tg; reset = rs;
        #1;
        check("instr_read", {31'd0, bus.instr_read}, {31'd0, m_phase == 1});
        check("active", {31'd0, active}, {31'd0, m_phase != 2});
        check("instr_address", bus.instr_address, m_pc);
        check("ifid_instr", IF_ID_Instruction, m_ifid_i);
        check("ifid_pc", IF_ID_PC, m_ifid_pc);
`ifdef FETCH_PERF_CNT_EN
        check("fetch_count", fetch_count, m_fc[31:0]);
        check("stall_cycles", stall_cycles, m_sc[31:0]);
`endif
        @(posedge clk);
        tga = {tg[31:2], 2'b00};
        if (rs) begin
            model_reset();
        end else if (m_phase == 0) begin
            if (!wr) m_phase = 1;
        end else if (m_phase == 1) begin
            acc = !wr && !st;
            if (acc) begin
                np = bt ? tga : (m_pend ? m_ptgt : m_pc + 32'd4);
                m_ifid_i = mem_word(m_pc); m_ifid_pc = m_pc;
                m_pc = np; m_pend = 0;
                if (np == 32'd0) m_phase = 2;
                if (m_fc < 64'hFFFFFFFF) m_fc++;
            end else begin
                if (bt) begin m_pend = 1; m_ptgt = tga; end
                if (m_sc < 64'hFFFFFFFF) m_sc++;
            end
        end else if (!wr) begin
            m_ifid_i = 32'h0;
        end
    endtask

    initial begin
        bus.waitrequest = 0; stall = 0; branch_taken = 0; branch_target = 0;
        reset = 1;
        repeat (2) @(posedge clk);
        model_reset();

        // first fetch
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        #1;
        check("tp1_ifid", IF_ID_Instruction, 32'h24020005);
        check("tp1_ifid_pc", IF_ID_PC, RV);
        check("tp1_addr", bus.instr_address, RV + 32'd4);

        // memory wait at BFC00008
        cycle(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0, 0, 0);
            #1 check("tp2_hold_addr", bus.instr_address, RV + 32'd8);
        end
        cycle(0, 0, 0, 0, 0);
        #1 check("tp2_accept", IF_ID_PC, RV + 32'd8);

        // branch with delay slot at BFC00010
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 1, 32'hBFC00100, 0);
        #1;
        check("tp3_slot", IF_ID_PC, RV + 32'h10);
        check("tp3_target", bus.instr_address, RV + 32'h100);

        // branch during stall; redirect kept pending
        cycle(0, 1, 1, 32'hBFC00200, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        #1;
        check("tp4_slot", IF_ID_PC, RV + 32'h100);
        check("tp4_target", bus.instr_address, RV + 32'h200);

        // jump to 0 halts
        cycle(0, 0, 1, 32'h0, 0);
        #1;
        check("tp5_slot", IF_ID_PC, RV + 32'h200);
        check("tp5_active", {31'd0, active}, 32'd0);
        check("tp5_read", {31'd0, bus.instr_read}, 32'd0);
        cycle(0, 0, 0, 0, 0);
        #1 check("tp5_nop", IF_ID_Instruction, 32'h0);

        // reset while stalled with a pending redirect
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 1, 32'hBFC00300, 0);
        cycle(0, 1, 0, 0, 1);
        #1;
        check("tp6_active", {31'd0, active}, 32'd1);
        check("tp6_ifid", IF_ID_Instruction, 32'h0);
        check("tp6_pc", bus.instr_address, RV);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        #1 check("tp6_no_redirect", bus.instr_address, RV + 32'd4);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tg;
            int r;
            bit rs;
            r = $urandom % 10;
            if (r == 0)      tg = {30'd0, 2'($urandom)};
            else if (r == 1) tg = 32'hFFFFFFF8 | 32'($urandom % 4);
            else             tg = RV + 32'($urandom % 1024);
            rs = (m_phase == 2 && ($urandom % 4) == 0) || (($urandom % 100) == 0);
            cycle(($urandom % 4) == 0, ($urandom % 5) == 0,
                  ($urandom % 7) == 0, tg, rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
